samp_packer: RTL

- Upstream front end of the sample queue.
- Takes a 16-bit measurement word stream and applies programmable decimation.
- Packs four accepted words plus an 8-bit header into one 72-bit sample, driven onto the queue's sample/sample_avail inputs.
- Runs a level-crossing trigger detector with hysteresis whose single-cycle trigger pulse drives the queue's trigger input; configured over the same 8-bit wishbone register bus.

---
 rtl/samp_pkg.sv | 31 +++
 rtl/samp_trigdet.sv | 66 ++++++
 rtl/samp_packer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/samp_pkg.sv
// samp_pkg: shared constants and types for the sample packer.
//   - register addresses on the 8-bit wishbone config bus
//   - header bit positions inside the 72-bit packed sample
//   - trigger FSM state encoding
package samp_pkg;

    localparam int SAMPLE_W = 72;
    localparam int WORD_W   = 16;

    localparam logic [3:0] ADR_CTRL     = 4'd0;
    localparam logic [3:0] ADR_DECIM    = 4'd1;
    localparam logic [3:0] ADR_LEVEL_LO = 4'd2;
    localparam logic [3:0] ADR_LEVEL_HI = 4'd3;
    localparam logic [3:0] ADR_HYST_LO  = 4'd4;
    localparam logic [3:0] ADR_HYST_HI  = 4'd5;
    localparam logic [3:0] ADR_SCOUNT0  = 4'd8;
    localparam logic [3:0] ADR_SCOUNT1  = 4'd9;
    localparam logic [3:0] ADR_SCOUNT2  = 4'd10;
    localparam logic [3:0] ADR_SCOUNT3  = 4'd11;

    localparam int HDR_TRIG    = 71;
    localparam int HDR_RESTART = 70;
    localparam int HDR_SEQ_LSB = 64;

    typedef enum logic [1:0] {
        TRIG_DISARMED = 2'd0,
        TRIG_ARMED    = 2'd1,
        TRIG_FIRED    = 2'd2
    } trig_state_t;

endpackage

// File: rtl/samp_trigdet.sv
// samp_trigdet: level-crossing trigger detector with hysteresis.
// Evaluated only on accepted words; each transition consumes one word.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   DISARMED  | waiting for the signal to go beyond level by hyst
//   ARMED     | armed; waiting for the signal to cross level
//   FIRED     | fired on the last accepted word; next word disarms
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   word         accepted measurement word
//   accept       word is valid for evaluation this cycle
//   edge_fall    0 = rising crossing, 1 = falling crossing
//   level, hyst  threshold and hysteresis
//   clear        force DISARMED (config change, enable/active drop)
//   fire         combinational: this accepted word fires the trigger
//   state        current FSM state
module samp_trigdet
    import samp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] word,
    input  logic        accept,
    input  logic        edge_fall,
    input  logic [15:0] level,
    input  logic [15:0] hyst,
    input  logic        clear,
    output logic        fire,
    output trig_state_t state
);

    logic [16:0] low_diff;
    logic [16:0] high_sum;
    logic [15:0] low_thr;
    logic [15:0] high_thr;
    logic        arm_hit;
    logic        fire_hit;

    // 17-bit intermediates: borrow/carry out selects the saturated value.
    always_comb begin
        low_diff = {1'b0, level} - {1'b0, hyst};
        high_sum = {1'b0, level} + {1'b0, hyst};
        low_thr  = low_diff[16] ? 16'h0000 : low_diff[15:0];
        high_thr = high_sum[16] ? 16'hFFFF : high_sum[15:0];
        arm_hit  = edge_fall ? (word > high_thr) : (word < low_thr);
        fire_hit = edge_fall ? (word <= level)   : (word >= level);
        fire     = accept && !clear && (state == TRIG_ARMED) && fire_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TRIG_DISARMED;
        end else if (clear) begin
            state <= TRIG_DISARMED;
        end else if (accept) begin
            case (state)
                TRIG_DISARMED: if (arm_hit)  state <= TRIG_ARMED;
                TRIG_ARMED:    if (fire_hit) state <= TRIG_FIRED;
                default:                     state <= TRIG_DISARMED;
            endcase
        end
    end

endmodule

// File: rtl/samp_packer.sv
// samp_packer: front end of the sample queue. Decimates a 16-bit word
// stream, packs four accepted words plus an 8-bit header into a 72-bit
// sample, and emits a trigger pulse aligned with the sample strobe.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_data, in_valid   measurement word stream (no backpressure)
//   active              sample queue is accepting samples
//   sample, sample_avail  packed sample and its one-cycle strobe
//   trigger             one-cycle trigger pulse, coincides with sample_avail
//   wb_*                8-bit wishbone config bus, always acked,
//                       combinational read data
module samp_packer
    import samp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic                active,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_avail,
    output logic                trigger,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    input  logic                wb_we_i,
    input  logic [15:0]         wb_adr_i,
    input  logic [7:0]          wb_dat_i,
    output logic [7:0]          wb_dat_o,
    output logic                wb_ack_o
);

    logic        enable;
    logic        edge_fall;
    logic [7:0]  decim;
    logic [15:0] level;
    logic [15:0] hyst;
    logic [31:0] sample_count;

    logic [7:0]  dec_cnt;
    logic [1:0]  word_pos;
    logic [5:0]  seq;
    logic        restart;
    logic        trig_pend;
    logic [15:0] lane0, lane1, lane2;

    logic        wb_wr;
    logic [3:0]  adr;
    logic        accept;
    logic        discard;
    logic        cfg_clear;
    logic        fire;
    logic        trig_now;
    logic [7:0]  hdr;
    trig_state_t trig_state;
    logic        unused_adr;

    assign adr        = wb_adr_i[3:0];
    assign unused_adr = ^wb_adr_i[15:4];
    assign wb_ack_o   = 1'b1;
    assign wb_wr      = wb_stb_i && wb_cyc_i && wb_we_i;

    assign accept    = in_valid && enable && (dec_cnt == 8'd0);
    assign discard   = !enable || !active;
    assign cfg_clear = wb_wr && ((adr == ADR_CTRL) || (adr == ADR_LEVEL_LO) ||
                                 (adr == ADR_LEVEL_HI));
    assign trig_now  = trig_pend || fire;

    always_comb begin
        hdr = 8'h00;
        hdr[HDR_TRIG - HDR_SEQ_LSB]    = trig_now;
        hdr[HDR_RESTART - HDR_SEQ_LSB] = restart;
        hdr[5:0]                       = seq;
    end

    samp_trigdet u_trigdet (
        .clk       (clk),
        .rst_n     (rst_n),
        .word      (in_data),
        .accept    (accept),
        .edge_fall (edge_fall),
        .level     (level),
        .hyst      (hyst),
        .clear     (discard || cfg_clear),
        .fire      (fire),
        .state     (trig_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= 1'b0;
            edge_fall <= 1'b0;
            decim     <= 8'h00;
            level     <= 16'h0000;
            hyst      <= 16'h0000;
        end else if (wb_wr) begin
            case (adr)
                ADR_CTRL:     begin
                    enable    <= wb_dat_i[0];
                    edge_fall <= wb_dat_i[1];
                end
                ADR_DECIM:    decim       <= wb_dat_i;
                ADR_LEVEL_LO: level[7:0]  <= wb_dat_i;
                ADR_LEVEL_HI: level[15:8] <= wb_dat_i;
                ADR_HYST_LO:  hyst[7:0]   <= wb_dat_i;
                ADR_HYST_HI:  hyst[15:8]  <= wb_dat_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        wb_dat_o = 8'h00;
        case (adr)
            ADR_CTRL:     wb_dat_o = {3'b000, restart, trig_state, edge_fall, enable};
            ADR_DECIM:    wb_dat_o = decim;
            ADR_LEVEL_LO: wb_dat_o = level[7:0];
            ADR_LEVEL_HI: wb_dat_o = level[15:8];
            ADR_HYST_LO:  wb_dat_o = hyst[7:0];
            ADR_HYST_HI:  wb_dat_o = hyst[15:8];
            ADR_SCOUNT0:  wb_dat_o = sample_count[7:0];
            ADR_SCOUNT1:  wb_dat_o = sample_count[15:8];
            ADR_SCOUNT2:  wb_dat_o = sample_count[23:16];
            ADR_SCOUNT3:  wb_dat_o = sample_count[31:24];
            default:      wb_dat_o = 8'h00;
        endcase
    end

    // Decimation counter: reloads on accept, counts down on skipped words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= 8'h00;
        end else if (!enable) begin
            dec_cnt <= 8'h00;
        end else if (accept) begin
            dec_cnt <= decim;
        end else if (in_valid && (dec_cnt != 8'd0)) begin
            dec_cnt <= dec_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_avail <= 1'b0;
            trigger      <= 1'b0;
            sample_count <= 32'h0;
            word_pos     <= 2'd0;
            seq          <= 6'd0;
            restart      <= 1'b1;
            trig_pend    <= 1'b0;
            lane0        <= 16'h0;
            lane1        <= 16'h0;
            lane2        <= 16'h0;
        end else begin
            sample_avail <= 1'b0;
            trigger      <= 1'b0;
            if (discard) begin
                // Partial group is lost; the next sample must flag restart.
                word_pos  <= 2'd0;
                restart   <= 1'b1;
                trig_pend <= 1'b0;
            end else if (accept) begin
                if (word_pos == 2'd3) begin
                    sample       <= {hdr, in_data, lane2, lane1, lane0};
                    sample_avail <= 1'b1;
                    trigger      <= trig_now;
                    seq          <= seq + 6'd1;
                    sample_count <= sample_count + 32'd1;
                    restart      <= 1'b0;
                    trig_pend    <= 1'b0;
                    word_pos     <= 2'd0;
                end else begin
                    case (word_pos)
                        2'd0:    lane0 <= in_data;
                        2'd1:    lane1 <= in_data;
                        default: lane2 <= in_data;
                    endcase
                    trig_pend <= trig_now;
                    word_pos  <= word_pos + 2'd1;
                end
            end
        end
    end

endmodule
